// File: rtl/shift_seq2x4_pkg.sv
// Shared types and constants for the shift_seq2x4 sequencer and its shifter datapath.
// The optional SHIFT_SEQ_EARLY_DONE_EN build uses lane_is_fixed() below.
package shift_seq_pkg;

  localparam int LANE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when another 1-bit shift in the given mode cannot change the lane:
  // zero for left and logical right, all-zeros or all-ones for arithmetic right.
  function automatic logic lane_is_fixed(input logic [LANE_W-1:0] x,
                                         input logic dir,
                                         input logic arith);
    if (dir && arith) begin
      return (x == '0) || (x == '1);
    end
    return (x == '0);
  endfunction

endpackage

// File: rtl/shift_seq2x4_if.sv
// Op request and result handshakes of shift_seq2x4.
// Both sides are strict valid/ready: a transfer happens on a rising clk edge where
// valid && ready are both high; the sender keeps its payload stable while valid is
// high and ready is low, and ready never depends combinationally on valid.
interface shift_seq2x4_if #(
  parameter int AMT_W = 3
);
  import shift_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_a;
  logic [LANE_W-1:0] in_b;
  logic              in_dir;
  logic              in_arith;
  logic [AMT_W-1:0]  in_amt;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_ya;
  logic [LANE_W-1:0] out_yb;

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_dir, in_arith, in_amt, out_ready,
    output in_ready, out_valid, out_ya, out_yb
  );

  // Issue logic / result consumer side
  modport master (
    output in_valid, in_a, in_b, in_dir, in_arith, in_amt, out_ready,
    input  in_ready, out_valid, out_ya, out_yb
  );

endinterface

// File: rtl/shift_seq2x4_shifter2x4.sv
// shifter2x4: combinational 1-bit shifter on two independent 4-bit lanes.
// dir=0 shifts left with zero fill; dir=1 shifts right, zero fill unless arith=1,
// in which case bit 3 is replicated.
module shifter2x4
  import shift_seq_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              dir,
  input  logic              arith,
  output logic [LANE_W-1:0] ya,
  output logic [LANE_W-1:0] yb
);

  // One-position shift of each lane; both lanes share dir/arith.
  always_comb begin
    ya = a;
    yb = b;
    if (!dir) begin
      ya = {a[LANE_W-2:0], 1'b0};
      yb = {b[LANE_W-2:0], 1'b0};
    end else begin
      ya = {arith & a[LANE_W-1], a[LANE_W-1:1]};
      yb = {arith & b[LANE_W-1], b[LANE_W-1:1]};
    end
  end

endmodule

// File: rtl/shift_seq2x4.sv
// shift_seq2x4: multi-bit shift sequencer. Accepts one op, applies `amt` 1-bit
// shifts (one per cycle) through the shared shifter2x4, then presents both lanes
// until the consumer takes them. Only one op is in flight; in_ready is high in
// IDLE only.
// Optional build macro: SHIFT_SEQ_EARLY_DONE_EN -- leave SHIFT as soon as both
// lanes have reached a value further shifts cannot change.
module shift_seq2x4
  import shift_seq_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_seq2x4_if.slave        bus,
  output logic                 busy,
  output state_t               state_dbg
);

  state_t            state, state_nxt;
  logic [LANE_W-1:0] lane_a, lane_a_nxt;
  logic [LANE_W-1:0] lane_b, lane_b_nxt;
  logic [AMT_W-1:0]  cnt, cnt_nxt;
  logic              dir_q, dir_nxt;
  logic              arith_q, arith_nxt;
  logic [LANE_W-1:0] sh_a, sh_b;
  logic              in_ready_c, out_valid_c;
  logic              last_shift;

  shifter2x4 u_shifter (
    .a     (lane_a),
    .b     (lane_b),
    .dir   (dir_q),
    .arith (arith_q),
    .ya    (sh_a),
    .yb    (sh_b)
  );

`ifdef SHIFT_SEQ_EARLY_DONE_EN
  // This shift is the last one if the count runs out or both lanes land on a
  // fixed point; further shifts would leave the result unchanged.
  always_comb begin
    last_shift = (cnt == AMT_W'(1)) ||
                 (lane_is_fixed(sh_a, dir_q, arith_q) &&
                  lane_is_fixed(sh_b, dir_q, arith_q));
  end
`else
  // This shift is the last one exactly when the count runs out.
  always_comb begin
    last_shift = (cnt == AMT_W'(1));
  end
`endif

  // State register and op registers; async reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lane_a  <= '0;
      lane_b  <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      lane_a  <= lane_a_nxt;
      lane_b  <= lane_b_nxt;
      cnt     <= cnt_nxt;
      dir_q   <= dir_nxt;
      arith_q <= arith_nxt;
    end
  end

  // Next-state, register updates and handshake outputs.
  always_comb begin
    state_nxt   = state;
    lane_a_nxt  = lane_a;
    lane_b_nxt  = lane_b;
    cnt_nxt     = cnt;
    dir_nxt     = dir_q;
    arith_nxt   = arith_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          lane_a_nxt = bus.in_a;
          lane_b_nxt = bus.in_b;
          dir_nxt    = bus.in_dir;
          arith_nxt  = bus.in_arith;
          cnt_nxt    = bus.in_amt;
          state_nxt  = (bus.in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        lane_a_nxt = sh_a;
        lane_b_nxt = sh_b;
        // Counter saturates at zero rather than wrapping.
        if (cnt != '0) begin
          cnt_nxt = cnt - AMT_W'(1);
        end
        if (last_shift) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_ya    = lane_a;
  assign bus.out_yb    = lane_b;
  assign busy          = (state == SHIFT) || (state == DONE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_shift_seq2x4.sv
// Bench for shift_seq2x4: reset values, a table of ops with hand-computed results,
// random ops against a small lane model, and hand sequences for stalls, ignored
// requests during SHIFT and reset mid-op.
module tb_shift_seq2x4;
  import shift_seq_pkg::*;

  localparam int AMT_W = 3;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_t state_dbg;

  shift_seq2x4_if #(.AMT_W(AMT_W)) bus ();

  shift_seq2x4 #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         lat_q[$];
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [3:0]       a;
    logic [3:0]       b;
    logic             dir;
    logic             arith;
    logic [AMT_W-1:0] amt;
    logic [3:0]       ya;
    logic [3:0]       yb;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_shift(input logic [3:0] x, input logic dir, input logic arith);
    if (!dir) return {x[2:0], 1'b0};
    if (arith) return {x[3], x[3:1]};
    return {1'b0, x[3:1]};
  endfunction

  function automatic logic [7:0] model_result(input logic [3:0] a, input logic [3:0] b,
                                              input logic dir, input logic arith,
                                              input int amt);
    logic [3:0] ra, rb;
    ra = a;
    rb = b;
    for (int k = 0; k < amt; k++) begin
      ra = model_shift(ra, dir, arith);
      rb = model_shift(rb, dir, arith);
    end
    return {ra, rb};
  endfunction

  // Cycles from the accept edge to the edge after which out_valid is seen.
  function automatic int model_lat(input logic [3:0] a, input logic [3:0] b,
                                   input logic dir, input logic arith, input int amt);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    logic [3:0] ra, rb;
    ra = a;
    rb = b;
    for (int k = 1; k <= amt; k++) begin
      ra = model_shift(ra, dir, arith);
      rb = model_shift(rb, dir, arith);
      if (model_shift(ra, dir, arith) == ra && model_shift(rb, dir, arith) == rb) return k;
    end
    return amt;
`else
    return amt;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic dir,
                        input logic arith, input logic [AMT_W-1:0] amt,
                        input logic [3:0] eya, input logic [3:0] eyb,
                        input int stall, input bit poke);
    int         lat;
    logic [7:0] exp_v;
    int         exp_lat;
    exp_q.push_back({eya, eyb});
    lat_q.push_back(model_lat(a, b, dir, arith, int'(amt)));
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_dir   = dir;
    bus.in_arith = arith;
    bus.in_amt   = amt;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 4'($urandom_range(0, 15));
    bus.in_b     = 4'($urandom_range(0, 15));
    bus.in_amt   = AMT_W'($urandom_range(0, 7));
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
      end
      check("in_ready_shift", 32'(bus.in_ready), 32'd0);
      check("busy_shift", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    exp_v   = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (!bus.out_valid) begin
      check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
      return;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("out_ya", 32'(bus.out_ya), 32'(exp_v[7:4]));
    check("out_yb", 32'(bus.out_yb), 32'(exp_v[3:0]));
    check("busy_done", 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_ya", 32'(bus.out_ya), 32'(exp_v[7:4]));
      check("stall_yb", 32'(bus.out_yb), 32'(exp_v[3:0]));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]       ra, rb;
    logic             rdir, rarith;
    logic [AMT_W-1:0] ramt;
    logic [7:0]       rexp;

    vecs[0] = '{4'b1010, 4'b0111, 1'b1, 1'b1, 3'd2, 4'b1110, 4'b0001};
    vecs[1] = '{4'b1010, 4'b0111, 1'b1, 1'b1, 3'd0, 4'b1010, 4'b0111};
    vecs[2] = '{4'b1111, 4'b0011, 1'b0, 1'b0, 3'd3, 4'b1000, 4'b1000};
    vecs[3] = '{4'b1000, 4'b1111, 1'b1, 1'b0, 3'd7, 4'b0000, 4'b0000};
    vecs[4] = '{4'b1001, 4'b0101, 1'b0, 1'b0, 3'd1, 4'b0010, 4'b1010};
    vecs[5] = '{4'b1001, 4'b0110, 1'b1, 1'b0, 3'd1, 4'b0100, 4'b0011};
    vecs[6] = '{4'b1001, 4'b0110, 1'b1, 1'b1, 3'd3, 4'b1111, 4'b0000};
    vecs[7] = '{4'b0100, 4'b1000, 1'b1, 1'b1, 3'd7, 4'b0000, 4'b1111};
    vecs[8] = '{4'b0011, 4'b1100, 1'b0, 1'b1, 3'd2, 4'b1100, 4'b0000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_dir    = 1'b0;
    bus.in_arith  = 1'b0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ya", 32'(bus.out_ya), 32'd0);
    check("rst_yb", 32'(bus.out_yb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of ops with hand-computed results.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].dir, vecs[i].arith, vecs[i].amt,
             vecs[i].ya, vecs[i].yb, 0, 1'b0);
    end

    // Request pulsed during SHIFT must be ignored.
    run_op(4'b1111, 4'b0011, 1'b0, 1'b0, 3'd3, 4'b1000, 4'b1000, 0, 1'b1);

    // Consumer stalls 5 cycles in DONE.
    run_op(4'b1010, 4'b0111, 1'b1, 1'b1, 3'd2, 4'b1110, 4'b0001, 5, 1'b0);

    // Random ops against the lane model.
    for (int i = 0; i < 20; i++) begin
      ra     = 4'($urandom_range(0, 15));
      rb     = 4'($urandom_range(0, 15));
      rdir   = 1'($urandom_range(0, 1));
      rarith = 1'($urandom_range(0, 1));
      ramt   = AMT_W'($urandom_range(0, 7));
      rexp   = model_result(ra, rb, rdir, rarith, int'(ramt));
      run_op(ra, rb, rdir, rarith, ramt, rexp[7:4], rexp[3:0], int'($urandom_range(0, 2)), 1'b0);
    end

    // Async reset mid-SHIFT after two shifts of a five-shift op.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'b1111;
    bus.in_b     = 4'b1010;
    bus.in_dir   = 1'b0;
    bus.in_arith = 1'b0;
    bus.in_amt   = 3'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_shift_busy", 32'(busy), 32'd1);
    check("mid_shift_ya", 32'(bus.out_ya), 32'b1100);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_ya", 32'(bus.out_ya), 32'd0);
    check("arst_yb", 32'(bus.out_yb), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset.
    run_op(4'b0110, 4'b1001, 1'b1, 1'b1, 3'd1, 4'b0011, 4'b1100, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
